// File: rtl/udp_txbuf_packer_if.sv
// udp_txbuf_packer_if
//   Bundles the application-side payload stream and the ros2_ether UDP TX
//   buffer handshake/read bus of udp_txbuf_packer.
//   master : the environment (application logic + ros2_ether) driving the packer
//   slave  : udp_txbuf_packer itself
//   Application side : s_start, s_dst_ip, s_src_port, s_dst_port, s_tdata,
//                      s_tvalid, s_tlast -> packer; s_tready, s_idle,
//                      s_truncated <- packer
//   ros2_ether side  : udp_txbuf_grant, udp_txbuf_addr, udp_txbuf_ce -> packer;
//                      udp_txbuf_rel, udp_txbuf_rdata <- packer
interface udp_txbuf_packer_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  s_start;
  logic [31:0]           s_dst_ip;
  logic [15:0]           s_src_port;
  logic [15:0]           s_dst_port;
  logic [7:0]            s_tdata;
  logic                  s_tvalid;
  logic                  s_tlast;
  logic                  s_tready;
  logic                  s_idle;
  logic                  s_truncated;
  logic                  udp_txbuf_rel;
  logic                  udp_txbuf_grant;
  logic [ADDR_WIDTH-1:0] udp_txbuf_addr;
  logic                  udp_txbuf_ce;
  logic [31:0]           udp_txbuf_rdata;

  modport master (
    output s_start, s_dst_ip, s_src_port, s_dst_port, s_tdata, s_tvalid, s_tlast,
    output udp_txbuf_grant, udp_txbuf_addr, udp_txbuf_ce,
    input  s_tready, s_idle, s_truncated, udp_txbuf_rel, udp_txbuf_rdata
  );

  modport slave (
    input  s_start, s_dst_ip, s_src_port, s_dst_port, s_tdata, s_tvalid, s_tlast,
    input  udp_txbuf_grant, udp_txbuf_addr, udp_txbuf_ce,
    output s_tready, s_idle, s_truncated, udp_txbuf_rel, udp_txbuf_rdata
  );
endinterface

// File: rtl/udp_txbuf_packer.sv
// udp_txbuf_packer
//   Upstream feeder for the ros2_ether UDP transmit buffer. Packs a byte-stream
//   payload plus header fields into a 2**ADDR_WIDTH x 32 word RAM:
//     word0 = dst IP, word1 = {src_port, dst_port}, word2 = {16'h0, len},
//     word3+ = payload, little-endian within each word, zero-filled tail.
//   The buffer is then released with a one-cycle udp_txbuf_rel pulse and read
//   by ros2_ether (registered, 1-cycle latency) until udp_txbuf_grant returns it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : udp_txbuf_packer_if.slave (payload stream + txbuf bus)
//   tx_pkt_count, tx_trunc_count : only when UDP_TXBUF_STATS_EN is defined
// Optional feature macro: UDP_TXBUF_STATS_EN (released / truncated packet counters).
module udp_txbuf_packer #(
  parameter int ADDR_WIDTH  = 6,
  parameter int MAX_PAYLOAD = (2**ADDR_WIDTH - 3) * 4
) (
  input  logic              clk,
  input  logic              rst_n,
  udp_txbuf_packer_if.slave bus
`ifdef UDP_TXBUF_STATS_EN
  ,
  output logic [31:0]       tx_pkt_count,
  output logic [15:0]       tx_trunc_count
`endif
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE, PAYLOAD, HDR_LEN, HDR_IP, HDR_PORT, RELEASE, WAIT_GRANT
  } state_t;

  state_t          state;
  logic [31:0]     dst_ip;
  logic [15:0]     src_port;
  logic [15:0]     dst_port;
  logic [15:0]     byte_cnt;
  logic [31:0]     pack;
  logic [31:0]     ram [2**ADDR_WIDTH];

  logic            accept;
  logic            store;
  logic            word_done;
  logic [31:0]     pack_next;
  logic            we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]     wdata;

  // s_tready is high exactly while in PAYLOAD, so it doubles as the state qualifier.
  assign accept    = bus.s_tvalid & bus.s_tready;
  // Bytes past MAX_PAYLOAD are accepted but never stored; MAX_PAYLOAD is a
  // multiple of 4, so the last stored word has already been flushed then.
  assign store     = accept & (byte_cnt < MAX_LEN);
  assign word_done = (byte_cnt[1:0] == 2'd3) | bus.s_tlast;
  // Pack register only ever holds lanes below the current one; upper lanes are 0,
  // which gives the zero fill of a partial final word for free.
  assign pack_next = pack | (32'(bus.s_tdata) << {byte_cnt[1:0], 3'b000});

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state)
      PAYLOAD: begin
        if (store && word_done) begin
          we    = 1'b1;
          waddr = ADDR_WIDTH'(byte_cnt[15:2] + 14'd3);
          wdata = pack_next;
        end
      end
      HDR_LEN: begin
        we    = 1'b1;
        waddr = ADDR_WIDTH'(2);
        wdata = {16'h0, byte_cnt};
      end
      HDR_IP: begin
        we    = 1'b1;
        waddr = ADDR_WIDTH'(0);
        wdata = dst_ip;
      end
      HDR_PORT: begin
        we    = 1'b1;
        waddr = ADDR_WIDTH'(1);
        wdata = {src_port, dst_port};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.udp_txbuf_rdata <= '0;
    end else if (bus.udp_txbuf_ce) begin
      bus.udp_txbuf_rdata <= ram[bus.udp_txbuf_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      bus.s_tready      <= 1'b0;
      bus.s_idle        <= 1'b1;
      bus.s_truncated   <= 1'b0;
      bus.udp_txbuf_rel <= 1'b0;
      dst_ip            <= '0;
      src_port          <= '0;
      dst_port          <= '0;
      byte_cnt          <= '0;
      pack              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_start) begin
            dst_ip          <= bus.s_dst_ip;
            src_port        <= bus.s_src_port;
            dst_port        <= bus.s_dst_port;
            byte_cnt        <= '0;
            pack            <= '0;
            bus.s_truncated <= 1'b0;
            bus.s_idle      <= 1'b0;
            bus.s_tready    <= 1'b1;
            state           <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            if (store) begin
              byte_cnt <= byte_cnt + 16'd1;
              pack     <= word_done ? 32'h0 : pack_next;
            end else begin
              bus.s_truncated <= 1'b1;
            end
            if (bus.s_tlast) begin
              bus.s_tready <= 1'b0;
              state        <= HDR_LEN;
            end
          end
        end
        HDR_LEN:  state <= HDR_IP;
        HDR_IP:   state <= HDR_PORT;
        HDR_PORT: begin
          bus.udp_txbuf_rel <= 1'b1;
          state             <= RELEASE;
        end
        RELEASE: begin
          bus.udp_txbuf_rel <= 1'b0;
          state             <= WAIT_GRANT;
        end
        WAIT_GRANT: begin
          if (bus.udp_txbuf_grant) begin
            bus.s_idle <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          bus.s_tready      <= 1'b0;
          bus.s_idle        <= 1'b1;
          bus.udp_txbuf_rel <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

`ifdef UDP_TXBUF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pkt_count   <= '0;
      tx_trunc_count <= '0;
    end else if (bus.udp_txbuf_rel) begin
      tx_pkt_count <= tx_pkt_count + 32'd1;
      if (bus.s_truncated && (tx_trunc_count != 16'hffff))
        tx_trunc_count <= tx_trunc_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_txbuf_packer.sv
module tb_udp_txbuf_packer;
  localparam int AW    = 6;
  localparam int DEPTH = 2**AW;
  localparam int MAXP  = (DEPTH - 3) * 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  udp_txbuf_packer_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef UDP_TXBUF_STATS_EN
  logic [31:0] tx_pkt_count;
  logic [15:0] tx_trunc_count;
`endif

  udp_txbuf_packer #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef UDP_TXBUF_STATS_EN
    ,
    .tx_pkt_count   (tx_pkt_count),
    .tx_trunc_count (tx_trunc_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit          exp_tready = 1'b0;
  bit          exp_idle   = 1'b1;
  bit          exp_rel    = 1'b0;
  bit          exp_trunc  = 1'b0;
  logic [31:0] mram  [DEPTH];
  bit          known [DEPTH];
  bit          packing    = 1'b0;
  logic [31:0] exp_rd     = '0;
  bit          exp_rd_vld = 1'b1;
  int          exp_pkts   = 0;
  int          exp_tcnt   = 0;
  bit          rd_manual  = 1'b0;
  logic [7:0]  pbytes [0:299];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    check32("s_tready", 32'(bus.s_tready), 32'(exp_tready));
    check32("s_idle", 32'(bus.s_idle), 32'(exp_idle));
    check32("udp_txbuf_rel", 32'(bus.udp_txbuf_rel), 32'(exp_rel));
    check32("s_truncated", 32'(bus.s_truncated), 32'(exp_trunc));
    if (exp_rd_vld)
      check32("udp_txbuf_rdata", bus.udp_txbuf_rdata, rst_n ? exp_rd : 32'h0);
`ifdef UDP_TXBUF_STATS_EN
    check32("tx_pkt_count", tx_pkt_count, 32'(exp_pkts));
    check32("tx_trunc_count", 32'(tx_trunc_count), 32'(exp_tcnt));
`endif
    // Predict what the coming edge captures into udp_txbuf_rdata.
    if (!rst_n) begin
      exp_rd     = 32'h0;
      exp_rd_vld = 1'b1;
    end else if (bus.udp_txbuf_ce) begin
      if (packing || !known[bus.udp_txbuf_addr]) begin
        exp_rd_vld = 1'b0;
      end else begin
        exp_rd     = mram[bus.udp_txbuf_addr];
        exp_rd_vld = 1'b1;
      end
    end
  end

  // Background random reader (yields to peek).
  initial begin
    bus.udp_txbuf_ce   = 1'b0;
    bus.udp_txbuf_addr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rd_manual) begin
        bus.udp_txbuf_ce   = 1'($urandom_range(1));
        bus.udp_txbuf_addr = AW'($urandom_range(DEPTH - 1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic peek(input string name, input int a, input logic [31:0] lit);
    rd_manual          = 1'b1;
    bus.udp_txbuf_ce   = 1'b1;
    bus.udp_txbuf_addr = AW'(a);
    tick;
    check32(name, bus.udp_txbuf_rdata, lit);
    bus.udp_txbuf_ce   = 1'b0;
    rd_manual          = 1'b0;
  endtask

  task automatic commit_model(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                              input int len);
    int stored;
    logic [31:0] w;
    stored = (len > MAXP) ? MAXP : len;
    mram[0] = ip;
    mram[1] = {sp, dp};
    mram[2] = {16'h0, 16'(stored)};
    known[0] = 1'b1; known[1] = 1'b1; known[2] = 1'b1;
    for (int wi = 0; wi < (stored + 3) / 4; wi++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * wi + b < stored) w[8*b +: 8] = pbytes[4 * wi + b];
      mram[3 + wi]  = w;
      known[3 + wi] = 1'b1;
    end
  endtask

  task automatic start_packet(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp);
    bus.s_start    = 1'b1;
    bus.s_dst_ip   = ip;
    bus.s_src_port = sp;
    bus.s_dst_port = dp;
    packing        = 1'b1;
    tick;
    bus.s_start = 1'b0;
    exp_idle    = 1'b0;
    exp_tready  = 1'b1;
    exp_trunc   = 1'b0;
  endtask

  // Sends a whole packet and returns in the first WAIT_GRANT cycle.
  task automatic fill_packet(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                             input int len, input int vprob);
    int i;
    i = 0;
    start_packet(ip, sp, dp);
    while (i < len) begin
      bus.s_tvalid = ($urandom_range(99) < vprob);
      bus.s_tdata  = pbytes[i];
      bus.s_tlast  = (i == len - 1);
      if ($urandom_range(9) == 0) begin
        bus.s_start    = 1'b1;
        bus.s_dst_ip   = $urandom;
        bus.s_src_port = 16'($urandom);
        bus.s_dst_port = 16'($urandom);
      end
      tick;
      bus.s_start = 1'b0;
      if (bus.s_tvalid) begin
        i++;
        if (i > MAXP) exp_trunc = 1'b1;
      end
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    exp_tready   = 1'b0;
    tick; tick; tick;
    exp_rel = 1'b1;
    packing = 1'b0;
    commit_model(ip, sp, dp, len);
    tick;
    exp_rel = 1'b0;
    exp_pkts++;
    if (exp_trunc && exp_tcnt < 65535) exp_tcnt++;
  endtask

  // Stays in WAIT_GRANT for 'delay' cycles with stray stimulus, then grants.
  task automatic grant_packet(input int delay);
    for (int d = 0; d < delay; d++) begin
      bus.s_start  = 1'($urandom_range(1));
      bus.s_dst_ip = $urandom;
      bus.s_tvalid = 1'($urandom_range(1));
      bus.s_tdata  = 8'($urandom);
      tick;
    end
    bus.udp_txbuf_grant = 1'b1;
    bus.s_start         = 1'($urandom_range(1));
    bus.s_dst_ip        = $urandom;
    tick;
    bus.udp_txbuf_grant = 1'b0;
    bus.s_start         = 1'b0;
    bus.s_tvalid        = 1'b0;
    exp_idle            = 1'b1;
  endtask

  initial begin
    string msg;
    int    len;
    bus.s_start = 1'b0; bus.s_dst_ip = '0; bus.s_src_port = '0; bus.s_dst_port = '0;
    bus.s_tdata = '0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.udp_txbuf_grant = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      known[k] = 1'b0;
      mram[k]  = '0;
    end
    #1 rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick; tick;

    // Packet 1: "UDP Send Test\n\0"
    msg = "UDP Send Test\n";
    for (int k = 0; k < 14; k++) pbytes[k] = msg[k];
    pbytes[14] = 8'h00;
    fill_packet(32'h0a01a8c0, 16'd1111, 16'd1234, 15, 70);
    peek("p1_word0", 0, 32'h0a01a8c0);
    peek("p1_word1", 1, 32'h045704d2);
    peek("p1_word2", 2, 32'h0000000f);
    peek("p1_word3", 3, 32'h20504455);
    peek("p1_word4", 4, 32'h646e6553);
    peek("p1_word5", 5, 32'h73655420);
    peek("p1_word6", 6, 32'h00000a74);
    grant_packet(2);
    tick;

    // Packet 2: single byte
    pbytes[0] = 8'hAA;
    fill_packet(32'hc0a80001, 16'h1000, 16'h2000, 1, 100);
    peek("p2_word2", 2, 32'h00000001);
    peek("p2_word3", 3, 32'h000000aa);
    check32("p2_truncated", 32'(bus.s_truncated), 32'h0);
    grant_packet(0);

    // Packet 3: 260 bytes, truncated to MAX_PAYLOAD
    for (int k = 0; k < 260; k++) pbytes[k] = 8'($urandom);
    fill_packet(32'h11223344, 16'h5555, 16'h6666, 260, 90);
    peek("p3_word2", 2, 32'h000000f4);
    check32("p3_truncated", 32'(bus.s_truncated), 32'h1);
    grant_packet(3);
`ifdef UDP_TXBUF_STATS_EN
    check32("stats_pkt_count", tx_pkt_count, 32'd3);
    check32("stats_trunc_count", 32'(tx_trunc_count), 32'd1);
`endif
    tick;

    // Reset mid-PAYLOAD after 7 bytes
    for (int k = 0; k < 7; k++) pbytes[k] = 8'($urandom);
    start_packet(32'hdeadbeef, 16'h0102, 16'h0304);
    for (int k = 0; k < 7; k++) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = pbytes[k];
      bus.s_tlast  = 1'b0;
      tick;
    end
    bus.s_tvalid = 1'b0;
    rst_n        = 1'b0;
    exp_tready = 1'b0; exp_idle = 1'b1; exp_rel = 1'b0; exp_trunc = 1'b0;
    exp_pkts = 0; exp_tcnt = 0;
    packing = 1'b0;
    for (int k = 3; k < DEPTH; k++) known[k] = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Next full packet after the abort
    for (int k = 0; k < 9; k++) pbytes[k] = 8'(8'h10 + k);
    fill_packet(32'h01020304, 16'h0a0b, 16'h0c0d, 9, 80);
    peek("ra_word3", 3, 32'h13121110);
    peek("ra_word5", 5, 32'h00000018);
    grant_packet(1);

    // Randomized packets
    for (int p = 0; p < 10; p++) begin
      len = ($urandom_range(3) == 0) ? int'($urandom_range(200, 260)) : int'($urandom_range(1, 40));
      for (int k = 0; k < len; k++) pbytes[k] = 8'($urandom);
      repeat ($urandom_range(2)) tick;
      fill_packet($urandom, 16'($urandom), 16'($urandom), len, int'($urandom_range(30, 100)));
      grant_packet(int'($urandom_range(5)));
    end
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
